// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the nibble-serial add/subtract block:
//   NIBBLE_W   width of the shared add/sub cell
//   state_t    control FSM states (IDLE, RUN, DONE)
//   nib_count  number of nibble steps for a given operand width
//   idx_width  width of the nibble index register for a given operand width
// -----------------------------------------------------------------------------
package addsub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nib_count(input int width);
        return width / NIBBLE_W;
    endfunction

    // At least one bit so a single-nibble build still has a legal index.
    function automatic int idx_width(input int width);
        int n;
        n = width / NIBBLE_W;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addsub_nibble_serial_if.sv
// -----------------------------------------------------------------------------
// addsub_nibble_serial_if
// Operand/result bus of the nibble-serial add/subtract block.
//   Operand side : start_valid, start_ready, op_a, op_b, subtract, carry_in
//   Result side  : res_valid, res_ready, result, carry_out, overflow
//   zero         : present only when ADDSUB_NIBBLE_SERIAL_ZERO_FLAG_EN is defined
// Modports:
//   master : operand producer / result consumer
//   slave  : the arithmetic block
// -----------------------------------------------------------------------------
interface addsub_nibble_serial_if #(
    parameter int WIDTH = 16
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             subtract;
    logic             carry_in;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
`ifdef ADDSUB_NIBBLE_SERIAL_ZERO_FLAG_EN
    logic             zero;
`endif

    modport master (
        output start_valid, op_a, op_b, subtract, carry_in, res_ready,
`ifdef ADDSUB_NIBBLE_SERIAL_ZERO_FLAG_EN
        input  zero,
`endif
        input  start_ready, res_valid, result, carry_out, overflow
    );

    modport slave (
        input  start_valid, op_a, op_b, subtract, carry_in, res_ready,
`ifdef ADDSUB_NIBBLE_SERIAL_ZERO_FLAG_EN
        output zero,
`endif
        output start_ready, res_valid, result, carry_out, overflow
    );

endinterface

// File: rtl/addsub_nibble_cell.sv
// -----------------------------------------------------------------------------
// addsub_nibble_cell
// Purely combinational 4-bit add/subtract cell: {o_cout, o_sum} = i_a + (i_b ^ {4{i_sub}}) + i_c
//   i_a, i_b : nibble operands
//   i_sub    : invert i_b (subtract)
//   i_c      : carry in
//   o_sum    : nibble sum
//   o_cout   : carry out
// -----------------------------------------------------------------------------
module addsub_nibble_cell
    import addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_sub,
    input  logic                i_c,
    output logic [NIBBLE_W-1:0] o_sum,
    output logic                o_cout
);

    logic [NIBBLE_W-1:0] w_b_eff;

    assign w_b_eff         = i_b ^ {NIBBLE_W{i_sub}};
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, w_b_eff} + {{NIBBLE_W{1'b0}}, i_c};

endmodule

// File: rtl/addsub_nibble_serial.sv
// -----------------------------------------------------------------------------
// addsub_nibble_serial
// Multi-cycle WIDTH-bit add/subtract built around one shared 4-bit cell.
// Operands are latched on accept, then one nibble per clock is processed,
// LSB nibble first, with the carry registered between steps. The result is
// held in DONE until the consumer takes it.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : operand/result bus (slave modport), see addsub_nibble_serial_if
//   busy  : operation in progress (state != IDLE)
// Optional feature macro: ADDSUB_NIBBLE_SERIAL_ZERO_FLAG_EN adds bus.zero,
// a registered all-zero flag of the result, valid with res_valid.
// -----------------------------------------------------------------------------
module addsub_nibble_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    addsub_nibble_serial_if.slave         bus,
    output logic                          busy
);

    localparam int                NIB  = nib_count(WIDTH);
    localparam int                IW   = idx_width(WIDTH);
    localparam logic [IW-1:0]     LAST = IW'(NIB - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_start_ready;
    logic                  w_res_valid;
    logic                  w_busy;
    logic                  w_accept;
    logic                  w_last;

    // Operand latch (data only, no reset needed)
    logic [WIDTH-1:0]      r_a;
    logic [WIDTH-1:0]      r_b;
    logic                  r_sub;

    logic                  r_carry;
    logic [IW-1:0]         r_idx;
    logic [WIDTH-1:0]      r_result;
    logic                  r_cout;
    logic                  r_ovf;

    logic [NIBBLE_W-1:0]   w_a_nib;
    logic [NIBBLE_W-1:0]   w_b_nib;
    logic [NIBBLE_W-1:0]   w_sum;
    logic                  w_cout;
    logic                  w_ovf;

    // Nibble index scaled by 4 selects the active slice.
    assign w_a_nib = r_a[{r_idx, 2'b00} +: NIBBLE_W];
    assign w_b_nib = r_b[{r_idx, 2'b00} +: NIBBLE_W];

    addsub_nibble_cell u_cell (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_sub  (r_sub),
        .i_c    (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Signed overflow: both addends share a sign that the result's MSB does not.
    // Only meaningful on the last step, where w_sum[3] is the word MSB.
    assign w_ovf = (r_a[WIDTH-1] == (r_b[WIDTH-1] ^ r_sub)) &&
                   (w_sum[NIBBLE_W-1] != r_a[WIDTH-1]);

    assign w_accept = bus.start_valid && w_start_ready;
    assign w_last   = (r_idx == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_start_ready = 1'b0;
        w_res_valid   = 1'b0;
        w_busy        = 1'b1;
        unique case (r_state)
            IDLE: begin
                w_start_ready = 1'b1;
                w_busy        = 1'b0;
                if (bus.start_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_res_valid = 1'b1;
                if (bus.res_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a   <= bus.op_a;
            r_b   <= bus.op_b;
            r_sub <= bus.subtract;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_carry <= bus.carry_in;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_result[{r_idx, 2'b00} +: NIBBLE_W] <= w_sum;
            r_carry                              <= w_cout;
            if (w_last) begin
                r_idx  <= '0;
                r_cout <= w_cout;
                r_ovf  <= w_ovf;
            end else begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

`ifdef ADDSUB_NIBBLE_SERIAL_ZERO_FLAG_EN
    logic r_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_zero <= 1'b1;
        end else if (r_state == RUN) begin
            r_zero <= r_zero && (w_sum == '0);
        end
    end

    assign bus.zero = r_zero;
`endif

    assign bus.start_ready = w_start_ready;
    assign bus.res_valid   = w_res_valid;
    assign bus.result      = r_result;
    assign bus.carry_out   = r_cout;
    assign bus.overflow    = r_ovf;
    assign busy            = w_busy;

endmodule

// File: tb/tb_addsub_nibble_serial.sv
// -----------------------------------------------------------------------------
// tb_addsub_nibble_serial
// Directed bench for addsub_nibble_serial (WIDTH=16) with hand-computed
// expected values. Optional zero flag is checked when
// ADDSUB_NIBBLE_SERIAL_ZERO_FLAG_EN is defined.
// -----------------------------------------------------------------------------
module tb_addsub_nibble_serial;

    localparam int WIDTH = 16;

    logic clk;
    logic rst_n;
    logic busy;

    int checks;
    int errors;

    addsub_nibble_serial_if #(.WIDTH(WIDTH)) bus ();

    addsub_nibble_serial #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present operands, wait for the accepting edge, then scramble the inputs
    // so any late sampling of them would corrupt the result.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic s, input logic c);
        @(negedge clk);
        bus.op_a        = a;
        bus.op_b        = b;
        bus.subtract    = s;
        bus.carry_in    = c;
        bus.start_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        bus.op_a        = 16'hA5A5;
        bus.op_b        = 16'h5A5A;
        bus.subtract    = ~s;
        bus.carry_in    = ~c;
    endtask

    // Edges after the accept edge until res_valid; -1 if it never rises.
    task automatic wait_result(output int edges);
        edges = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.res_valid === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic ack_result();
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.start_ready, bus.res_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ctrl: start_ready/res_valid/busy=%b required 100",
                     {bus.start_ready, bus.res_valid, busy});
        end
        checks++;
        if ({bus.result, bus.carry_out, bus.overflow} !== 18'h0) begin
            errors++;
            $display("FAIL reset_data: result=%h cout=%b ovf=%b required 0000 0 0",
                     bus.result, bus.carry_out, bus.overflow);
        end
`ifdef ADDSUB_NIBBLE_SERIAL_ZERO_FLAG_EN
        checks++;
        if (bus.zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_zero: zero=%b required 0", bus.zero);
        end
`endif
    endtask

    task automatic run_vector(input string name, input logic [15:0] a, input logic [15:0] b,
                              input logic s, input logic c, input logic [15:0] exp_r,
                              input logic exp_c, input logic exp_v, input logic exp_z);
        int edges;
        start_op(a, b, s, c);
        checks++;
        if ({busy, bus.start_ready} !== 2'b10) begin
            errors++;
            $display("FAIL %s_busy: busy/start_ready=%b required 10", name, {busy, bus.start_ready});
        end
        wait_result(edges);
        checks++;
        if (edges != 4) begin
            errors++;
            $display("FAIL %s_latency: res_valid after %0d edges required 4", name, edges);
        end
        checks++;
        if ({bus.result, bus.carry_out, bus.overflow} !== {exp_r, exp_c, exp_v}) begin
            errors++;
            $display("FAIL %s_result: result=%h cout=%b ovf=%b required %h %b %b",
                     name, bus.result, bus.carry_out, bus.overflow, exp_r, exp_c, exp_v);
        end
`ifdef ADDSUB_NIBBLE_SERIAL_ZERO_FLAG_EN
        checks++;
        if (bus.zero !== exp_z) begin
            errors++;
            $display("FAIL %s_zero: zero=%b required %b", name, bus.zero, exp_z);
        end
`else
        if (exp_z) begin
        end
`endif
        ack_result();
        checks++;
        if ({bus.res_valid, bus.start_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL %s_handshake: res_valid/start_ready/busy=%b required 010",
                     name, {bus.res_valid, bus.start_ready, busy});
        end
    endtask

    task automatic test_add();
        run_vector("add_carry_nibble", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        run_vector("add_wrap",         16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_sub();
        run_vector("sub_negative", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_vector("sub_overflow", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        int edges;
        start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        wait_result(edges);
        checks++;
        if (edges != 4) begin
            errors++;
            $display("FAIL bp_latency: res_valid after %0d edges required 4", edges);
        end
        for (int i = 0; i < 5; i++) begin
            bus.start_valid = i[0];
            bus.op_a        = 16'h1111 * i[15:0];
            bus.op_b        = 16'h2222;
            @(posedge clk);
            #1;
            checks++;
            if ({bus.res_valid, bus.start_ready, busy, bus.result, bus.carry_out, bus.overflow}
                !== {3'b101, 16'h1010, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid/ready/busy=%b result=%h cout=%b ovf=%b required 101 1010 0 0",
                         i, {bus.res_valid, bus.start_ready, busy}, bus.result, bus.carry_out, bus.overflow);
            end
        end
        bus.start_valid = 1'b0;
        ack_result();
        checks++;
        if ({bus.start_ready, bus.res_valid, busy, bus.result} !== {3'b100, 16'h1010}) begin
            errors++;
            $display("FAIL bp_release: ready/valid/busy=%b result=%h required 100 1010",
                     {bus.start_ready, bus.res_valid, busy}, bus.result);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_new_op: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_midrun();
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.start_ready, bus.res_valid, busy, bus.result, bus.carry_out, bus.overflow}
            !== {3'b100, 16'h0000, 2'b00}) begin
            errors++;
            $display("FAIL midrun_reset: ready/valid/busy=%b result=%h cout=%b ovf=%b required 100 0000 0 0",
                     {bus.start_ready, bus.res_valid, busy}, bus.result, bus.carry_out, bus.overflow);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_vector("after_reset", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        bus.start_valid = 1'b0;
        bus.res_ready   = 1'b0;
        bus.op_a        = '0;
        bus.op_b        = '0;
        bus.subtract    = 1'b0;
        bus.carry_in    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_add();
        test_sub();
        test_backpressure();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
